// File: rtl/data_memory_arbiter.sv
// Two-port round-robin arbiter and 3-cycle access sequencer for the data memory.
// Optional DMEM_ARB_FIXED_PRIO_EN: port 0 always wins over port 1.
module data_memory_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req,
  input  logic                  p0_write,
  input  logic [1:0]            p0_size,
  input  logic                  p0_sign_ext,
  input  logic [DATA_WIDTH-1:0] p0_address,
  input  logic [DATA_WIDTH-1:0] p0_data_to_write,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  input  logic                  p1_req,
  input  logic                  p1_write,
  input  logic [1:0]            p1_size,
  input  logic                  p1_sign_ext,
  input  logic [DATA_WIDTH-1:0] p1_address,
  input  logic [DATA_WIDTH-1:0] p1_data_to_write,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_error,
  output logic                  memory_enable_write,
  output logic                  memory_enable_read,
  output logic [1:0]            memory_size,
  output logic                  memory_sign_ext,
  output logic [DATA_WIDTH-1:0] memory_address,
  output logic [DATA_WIDTH-1:0] memory_data_to_write,
  input  logic [DATA_WIDTH-1:0] memory_data_read,
  input  logic                  misaligned_exception
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  winner_q, winner_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_re_q, mem_re_d;
  logic [1:0]            mem_size_q, mem_size_d;
  logic                  mem_sext_q, mem_sext_d;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  resp_error_q, resp_error_d;

  logic any_req;
  logic pick1;
  logic grant_en;

  assign any_req  = p0_req | p1_req;
  assign grant_en = rst_n & (state_q == IDLE);

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign pick1 = p1_req & ~p0_req;
`else
  // On a tie, the port that did not win last time goes first
  assign pick1 = p1_req & (~p0_req | ~last_grant_q);
`endif

  assign p0_gnt = grant_en & any_req & ~pick1;
  assign p1_gnt = grant_en & pick1;

  assign p0_rvalid = (state_q == RESP) & ~winner_q;
  assign p1_rvalid = (state_q == RESP) & winner_q;

  assign resp_data            = resp_data_q;
  assign resp_error           = resp_error_q;
  assign memory_enable_write  = mem_we_q;
  assign memory_enable_read   = mem_re_q;
  assign memory_size          = mem_size_q;
  assign memory_sign_ext      = mem_sext_q;
  assign memory_address       = mem_addr_q;
  assign memory_data_to_write = mem_wdata_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    winner_d     = winner_q;
    mem_we_d     = 1'b0;
    mem_re_d     = 1'b0;
    mem_size_d   = '0;
    mem_sext_d   = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    resp_data_d  = resp_data_q;
    resp_error_d = resp_error_q;
    unique case (1'b1)
      state_q == IDLE: begin
        if (any_req) begin
          state_d      = ACCESS;
          winner_d     = pick1;
          last_grant_d = pick1;
          mem_we_d     = pick1 ? p1_write : p0_write;
          mem_re_d     = pick1 ? ~p1_write : ~p0_write;
          mem_size_d   = pick1 ? p1_size : p0_size;
          mem_sext_d   = pick1 ? p1_sign_ext : p0_sign_ext;
          mem_addr_d   = pick1 ? p1_address : p0_address;
          mem_wdata_d  = pick1 ? p1_data_to_write
                               : p0_data_to_write;
        end
      end
      state_q == ACCESS: begin
        state_d = RESP;
        // size 11 is not a real access: report nothing
        if (mem_we_q || mem_size_q == 2'b11)
          resp_data_d = '0;
        else
          resp_data_d = memory_data_read;
        resp_error_d = (mem_size_q != 2'b11)
                     & misaligned_exception;
      end
      state_q == RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      winner_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_size_q   <= '0;
      mem_sext_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
      mem_size_q   <= mem_size_d;
      mem_sext_q   <= mem_sext_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a byte-array data memory model.
// Expectations follow DMEM_ARB_FIXED_PRIO_EN when it is defined.
module tb_data_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_write, p0_sign_ext;
  logic [1:0]  p0_size;
  logic [31:0] p0_address, p0_data_to_write;
  logic        p0_gnt, p0_rvalid;
  logic        p1_req, p1_write, p1_sign_ext;
  logic [1:0]  p1_size;
  logic [31:0] p1_address, p1_data_to_write;
  logic        p1_gnt, p1_rvalid;
  logic [31:0] resp_data;
  logic        resp_error;
  logic        memory_enable_write, memory_enable_read;
  logic [1:0]  memory_size;
  logic        memory_sign_ext;
  logic [31:0] memory_address, memory_data_to_write;
  logic [31:0] memory_data_read;
  logic        misaligned_exception;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_memory_arbiter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_write(p0_write), .p0_size(p0_size),
    .p0_sign_ext(p0_sign_ext), .p0_address(p0_address),
    .p0_data_to_write(p0_data_to_write),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_write(p1_write), .p1_size(p1_size),
    .p1_sign_ext(p1_sign_ext), .p1_address(p1_address),
    .p1_data_to_write(p1_data_to_write),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .resp_data(resp_data), .resp_error(resp_error),
    .memory_enable_write(memory_enable_write),
    .memory_enable_read(memory_enable_read),
    .memory_size(memory_size), .memory_sign_ext(memory_sign_ext),
    .memory_address(memory_address),
    .memory_data_to_write(memory_data_to_write),
    .memory_data_read(memory_data_read),
    .misaligned_exception(misaligned_exception)
  );

  // Little-endian byte memory, async read, write on rising edge
  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] idx;

  assign idx = memory_address[7:0];

  always_comb begin
    misaligned_exception =
      (memory_size == 2'b01 && memory_address[0]) ||
      (memory_size == 2'b10 && memory_address[1:0] != 2'b00);
    memory_data_read = '0;
    if (memory_enable_read && !misaligned_exception) begin
      case (memory_size)
        2'b00: memory_data_read = memory_sign_ext
          ? {{24{mem[idx][7]}}, mem[idx]}
          : {24'h0, mem[idx]};
        2'b01: memory_data_read = memory_sign_ext
          ? {{16{mem[8'(idx+1)][7]}}, mem[8'(idx+1)], mem[idx]}
          : {16'h0, mem[8'(idx+1)], mem[idx]};
        2'b10: memory_data_read = {mem[8'(idx+3)], mem[8'(idx+2)],
                                   mem[8'(idx+1)], mem[idx]};
        default: memory_data_read = '0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (memory_enable_write && !misaligned_exception) begin
      case (memory_size)
        2'b00: mem[idx] <= memory_data_to_write[7:0];
        2'b01: begin
          mem[idx]         <= memory_data_to_write[7:0];
          mem[8'(idx+1)]   <= memory_data_to_write[15:8];
        end
        2'b10: begin
          mem[idx]         <= memory_data_to_write[7:0];
          mem[8'(idx+1)]   <= memory_data_to_write[15:8];
          mem[8'(idx+2)]   <= memory_data_to_write[23:16];
          mem[8'(idx+3)]   <= memory_data_to_write[31:24];
        end
        default: ;
      endcase
    end
  end

  function automatic logic [31:0] rd_word(input logic [7:0] a);
    return {mem[8'(a+3)], mem[8'(a+2)], mem[8'(a+1)], mem[a]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input int port, input logic wr,
                       input logic [1:0] sz, input logic se,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (port == 0) begin
      p0_req = 1'b1; p0_write = wr; p0_size = sz;
      p0_sign_ext = se; p0_address = addr; p0_data_to_write = wd;
    end else begin
      p1_req = 1'b1; p1_write = wr; p1_size = sz;
      p1_sign_ext = se; p1_address = addr; p1_data_to_write = wd;
    end
  endtask

  // Entered at posedge+1 with the DUT in IDLE; leaves it there
  task automatic run_access(input string tag, input int port,
                            input logic wr, input logic [1:0] sz,
                            input logic se, input logic [31:0] addr,
                            input logic [31:0] wd,
                            input logic [31:0] exp_data,
                            input logic exp_err);
    drive(port, wr, sz, se, addr, wd);
    @(negedge clk);
    chk1({tag, "_gnt"}, port == 0 ? p0_gnt : p1_gnt, 1'b1);
    chk1({tag, "_other_gnt"}, port == 0 ? p1_gnt : p0_gnt, 1'b0);
    @(posedge clk); #1;
    p0_req = 1'b0; p1_req = 1'b0;
    @(negedge clk);
    chk1({tag, "_acc_we"}, memory_enable_write, wr);
    chk1({tag, "_acc_re"}, memory_enable_read, ~wr);
    chk({tag, "_acc_addr"}, memory_address, addr);
    chk1({tag, "_acc_norv"}, p0_rvalid | p1_rvalid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk1({tag, "_rvalid"}, port == 0 ? p0_rvalid : p1_rvalid, 1'b1);
    chk1({tag, "_other_rv"}, port == 0 ? p1_rvalid : p0_rvalid, 1'b0);
    chk({tag, "_rdata"}, resp_data, exp_data);
    chk1({tag, "_rerr"}, resp_error, exp_err);
    chk1({tag, "_resp_en"}, memory_enable_write | memory_enable_read,
         1'b0);
    @(posedge clk); #1;
  endtask

  logic exp_win [4];

  initial begin
    rst_n = 1'b0;
    p0_req = 1'b1; p0_write = 1'b0; p0_size = 2'b10;
    p0_sign_ext = 1'b0; p0_address = '0; p0_data_to_write = '0;
    p1_req = 1'b0; p1_write = 1'b0; p1_size = 2'b10;
    p1_sign_ext = 1'b0; p1_address = '0; p1_data_to_write = '0;
    repeat (2) @(negedge clk);
    chk1("rst_p0_gnt", p0_gnt, 1'b0);
    chk1("rst_rvalid", p0_rvalid | p1_rvalid, 1'b0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk1("rst_resp_err", resp_error, 1'b0);
    chk1("rst_mem_en", memory_enable_write | memory_enable_read, 1'b0);
    chk("rst_mem_addr", memory_address, 32'h0);
    p0_req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_access("sw0", 0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF,
               32'h0, 1'b0);
    chk("sw0_mem", rd_word(8'h10), 32'hDEADBEEF);
    run_access("lw0", 0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,
               32'hDEADBEEF, 1'b0);
    run_access("sw1", 1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h80011234,
               32'h0, 1'b0);
    run_access("lh1", 1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0,
               32'hFFFF8001, 1'b0);
    run_access("sz11", 1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0,
               32'h0, 1'b0);

    // Tie with both requests held; last winner was port 1
`ifdef DMEM_ARB_FIXED_PRIO_EN
    exp_win = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_win = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    drive(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    drive(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1($sformatf("tie%0d_p1_gnt", i), p1_gnt, exp_win[i]);
      chk1($sformatf("tie%0d_p0_gnt", i), p0_gnt, ~exp_win[i]);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk1($sformatf("tie%0d_p1_rv", i), p1_rvalid, exp_win[i]);
      chk1($sformatf("tie%0d_p0_rv", i), p0_rvalid, ~exp_win[i]);
      chk($sformatf("tie%0d_data", i), resp_data, 32'h80011234);
      @(posedge clk); #1;
    end
    p0_req = 1'b0; p1_req = 1'b0;
    @(posedge clk); #1;

    run_access("sw_mis", 0, 1'b1, 2'b10, 1'b0, 32'h13, 32'hA5A5A5A5,
               32'h0, 1'b1);
    chk("mis_mem_lo", rd_word(8'h10), 32'h80011234);
    chk("mis_mem_hi", rd_word(8'h14), 32'h0);

    // Reset falls inside the ACCESS cycle of a store
    drive(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h55);
    @(negedge clk);
    chk1("rmid_gnt", p0_gnt, 1'b1);
    @(posedge clk); #1;
    p0_req = 1'b0;
    @(negedge clk);
    chk1("rmid_we_before", memory_enable_write, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("rmid_we_drop", memory_enable_write, 1'b0);
    chk1("rmid_re_drop", memory_enable_read, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1($sformatf("rmid_norv%0d", i), p0_rvalid | p1_rvalid, 1'b0);
    end
    chk("rmid_mem", rd_word(8'h20), 32'h0);
    @(posedge clk); #1;
    drive(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    drive(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    chk1("rmid_tie_p0", p0_gnt, 1'b1);
    chk1("rmid_tie_p1", p1_gnt, 1'b0);
    @(posedge clk); #1;
    p0_req = 1'b0; p1_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Port 1 arrives while port 0 is in RESP
    drive(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    chk1("late_p0_gnt", p0_gnt, 1'b1);
    @(posedge clk); #1;
    p0_req = 1'b0;
    @(posedge clk); #1;
    drive(1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    @(negedge clk);
    chk1("late_p1_wait", p1_gnt, 1'b0);
    chk1("late_p0_rv", p0_rvalid, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("late_p1_gnt", p1_gnt, 1'b1);
    @(posedge clk); #1;
    p1_req = 1'b0;
    @(negedge clk);
    chk1("late_p1_norv", p1_rvalid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("late_p1_rv", p1_rvalid, 1'b1);
    chk("late_p1_data", resp_data, 32'hFFFFFF80);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
